adder: RTL and testbench

ADDER -- requirements
Module: adder

---
 rtl/adder.sv | 231 +++++++++++++++++++++++
 tb/tb_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder.sv
// adder: IEEE-754 binary32 adder with stb/ack handshakes on both operands
// and the result. Multi-cycle FSM: alignment and normalisation move one bit
// per cycle, so latency depends on the operand exponents.
module adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
    NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] BIAS         = 10'sd127;
  localparam logic signed [9:0] EMIN         = -10'sd126;
  localparam logic signed [9:0] EMAX         = 10'sd127;
  // Beyond this exponent gap every mantissa bit lands in sticky anyway.
  localparam logic signed [9:0] COLLAPSE     = 10'sd27;
  localparam logic signed [9:0] NEG_COLLAPSE = -10'sd27;
  localparam logic [31:0]       QNAN         = 32'hFFC00000;

  state_t state, state_next;

  logic [31:0]       a, b, z;
  logic              a_s, b_s, z_s;
  logic signed [9:0] a_e, b_e, z_e;
  logic signed [9:0] exp_diff;
  logic [26:0]       a_m, b_m;
  logic [23:0]       z_m;
  logic [27:0]       sum;
  logic              guard, round_bit, sticky;

  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              special_hit;
  logic [31:0]       special_z;

  // Round-to-nearest-even increment decision.
  function automatic logic round_up(input logic lsb, input logic g,
                                    input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  // Assemble the binary32 word, saturating overflow to infinity.
  function automatic logic [31:0] pack_word(input logic s,
                                            input logic signed [9:0] e,
                                            input logic [23:0] m);
    logic [7:0] ef;
    ef = 8'(e + BIAS);
    if (m == 24'd0)
      pack_word = 32'd0;
    else if (e > EMAX)
      pack_word = {s, 8'hFF, 23'd0};
    else if (e == EMIN && !m[23])
      pack_word = {s, 8'h00, m[22:0]};
    else
      pack_word = {s, ef, m[22:0]};
  endfunction

  assign exp_diff = a_e - b_e;

  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_zero = (a[30:0] == 31'd0);
  assign b_zero = (b[30:0] == 31'd0);

  // Special-operand result, evaluated in priority order.
  always_comb begin
    special_hit = 1'b1;
    special_z   = 32'd0;
    if (a_nan || b_nan)
      special_z = QNAN;
    else if (a_inf)
      special_z = (b_inf && (a[31] != b[31])) ? QNAN : {a[31], 8'hFF, 23'd0};
    else if (b_inf)
      special_z = {b[31], 8'hFF, 23'd0};
    else if (a_zero && b_zero)
      special_z = {a[31] & b[31], 31'd0};
    else if (a_zero)
      special_z = b;
    else if (b_zero)
      special_z = a;
    else
      special_hit = 1'b0;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      GET_A:   if (input_a_ack && input_a_stb) state_next = GET_B;
      GET_B:   if (input_b_ack && input_b_stb) state_next = UNPACK;
      UNPACK:  state_next = SPECIAL;
      SPECIAL: state_next = special_hit ? PUT_Z : ALIGN;
      ALIGN:   if (exp_diff == 10'sd0) state_next = ADD_0;
      ADD_0:   state_next = ADD_1;
      ADD_1:   state_next = NORM_1;
      NORM_1: begin
        // An exact zero has nothing to normalise; skip the long walk to EMIN.
        if (z_m[23] || (z_e <= EMIN) || (z_m == 24'd0 && !guard && !round_bit))
          state_next = NORM_2;
      end
      NORM_2:  if (z_e >= EMIN) state_next = ROUND;
      ROUND:   state_next = PACK;
      PACK:    state_next = PUT_Z;
      PUT_Z:   if (output_z_stb && output_z_ack) state_next = GET_A;
      default: state_next = GET_A;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= 32'd0;
    end else begin
      state        <= state_next;
      input_a_ack  <= (state == GET_A) && !(input_a_ack && input_a_stb);
      input_b_ack  <= (state == GET_B) && !(input_b_ack && input_b_stb);
      output_z_stb <= (state == PUT_Z) && !(output_z_stb && output_z_ack);
      if (state == PUT_Z && !output_z_stb)
        output_z <= z;
    end
  end

  // Arithmetic datapath; control reset alone decides what it means.
  always_ff @(posedge clk) begin
    case (state)
      GET_A: if (input_a_ack && input_a_stb) a <= input_a;
      GET_B: if (input_b_ack && input_b_stb) b <= input_b;
      UNPACK: begin
        a_m <= {(a[30:23] != 8'd0), a[22:0], 3'b000};
        b_m <= {(b[30:23] != 8'd0), b[22:0], 3'b000};
        a_e <= (a[30:23] == 8'd0) ? EMIN : $signed({2'b00, a[30:23]}) - BIAS;
        b_e <= (b[30:23] == 8'd0) ? EMIN : $signed({2'b00, b[30:23]}) - BIAS;
        a_s <= a[31];
        b_s <= b[31];
      end
      SPECIAL: z <= special_z;
      ALIGN: begin
        if (exp_diff > 10'sd0) begin
          if (exp_diff >= COLLAPSE) begin
            b_m <= {26'd0, |b_m};
            b_e <= a_e;
          end else begin
            b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
            b_e <= b_e + 10'sd1;
          end
        end else if (exp_diff < 10'sd0) begin
          if (exp_diff <= NEG_COLLAPSE) begin
            a_m <= {26'd0, |a_m};
            a_e <= b_e;
          end else begin
            a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
            a_e <= a_e + 10'sd1;
          end
        end
      end
      ADD_0: begin
        z_e <= a_e;
        if (a_s == b_s) begin
          sum <= {1'b0, a_m} + {1'b0, b_m};
          z_s <= a_s;
        end else if (a_m >= b_m) begin
          sum <= {1'b0, a_m - b_m};
          z_s <= (a_m == b_m) ? 1'b0 : a_s;
        end else begin
          sum <= {1'b0, b_m - a_m};
          z_s <= b_s;
        end
      end
      ADD_1: begin
        if (sum[27]) begin
          z_m       <= sum[27:4];
          guard     <= sum[3];
          round_bit <= sum[2];
          sticky    <= sum[1] | sum[0];
          z_e       <= z_e + 10'sd1;
        end else begin
          z_m       <= sum[26:3];
          guard     <= sum[2];
          round_bit <= sum[1];
          sticky    <= sum[0];
        end
      end
      NORM_1: begin
        if (state_next == NORM_1) begin
          z_m       <= {z_m[22:0], guard};
          guard     <= round_bit;
          round_bit <= 1'b0;
          z_e       <= z_e - 10'sd1;
        end
      end
      NORM_2: begin
        if (z_e < EMIN) begin
          z_m       <= {1'b0, z_m[23:1]};
          guard     <= z_m[0];
          round_bit <= guard;
          sticky    <= sticky | round_bit;
          z_e       <= z_e + 10'sd1;
        end
      end
      ROUND: begin
        if (round_up(z_m[0], guard, round_bit, sticky)) begin
          if (&z_m) begin
            z_m <= 24'h800000;
            z_e <= z_e + 10'sd1;
          end else begin
            z_m <= z_m + 24'd1;
          end
        end
      end
      PACK: z <= pack_word(z_s, z_e, z_m);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_adder.sv
// tb_adder: scoreboard bench for the binary32 adder. Expected sums are
// pushed when operands are driven and popped when the result appears.
module tb_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = 32'd0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] input_b = 32'd0;
  logic        input_b_stb = 1'b0;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          excl_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  adder dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  // At most one handshake signal may be high at a time.
  always @(negedge clk)
    if (rst && ((input_a_ack && input_b_ack) || (input_a_ack && output_z_stb) ||
                (input_b_ack && output_z_stb)))
      excl_bad <= excl_bad + 1;

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, output bit ok);
    int t;
    ok = 1'b1;
    input_a = a;
    input_a_stb = 1'b1;
    t = 0;
    while (input_a_ack !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) ok = 1'b0;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_b = b;
    input_b_stb = 1'b1;
    t = 0;
    while (input_b_ack !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) ok = 1'b0;
    @(posedge clk); #1;
    input_b_stb = 1'b0;
  endtask

  task automatic wait_z(output logic [31:0] z, output int lat, output bit ok);
    lat = 0;
    while (output_z_stb !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    ok = (output_z_stb === 1'b1);
    z = output_z;
  endtask

  task automatic ack_z();
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL reset_a_ack got %b want 0", input_a_ack); end
    checks++; if (input_b_ack !== 1'b0) begin errors++; $display("FAIL reset_b_ack got %b want 0", input_b_ack); end
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL reset_z_stb got %b want 0", output_z_stb); end
    checks++; if (output_z !== 32'd0) begin errors++; $display("FAIL reset_z got %h want 00000000", output_z); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL release_a_ack got %b want 0", input_a_ack); end
    @(posedge clk); #1;
    checks++; if (input_a_ack !== 1'b1) begin errors++; $display("FAIL first_a_ack got %b want 1", input_a_ack); end
  endtask

  task automatic test_arith();
    vec_t v[8];
    logic [31:0] z, want;
    int lat;
    bit hs_ok, z_ok;
    v[0] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
    v[1] = '{32'h3F800000, 32'hC0000000, 32'hBF800000};
    v[2] = '{32'hBF800000, 32'h40000000, 32'h3F800000};
    v[3] = '{32'hBF800000, 32'hC0000000, 32'hC0400000};
    v[4] = '{32'h3FC00000, 32'h40200000, 32'h40800000};
    v[5] = '{32'h3F800000, 32'hBF800000, 32'h00000000};
    v[6] = '{32'h00000001, 32'h00000001, 32'h00000002};
    v[7] = '{32'h7F000000, 32'h00000001, 32'h7F000000};
    foreach (v[i]) begin
      exp_q.push_back(v[i].z);
      drive_op(v[i].a, v[i].b, hs_ok);
      wait_z(z, lat, z_ok);
      want = exp_q.pop_front();
      checks++;
      if (!hs_ok || !z_ok || z !== want) begin
        errors++; $display("FAIL arith[%0d] got %h want %h (stb seen %b)", i, z, want, z_ok);
      end
      checks++;
      if (dut.z_s !== want[31]) begin
        errors++; $display("FAIL arith_sign[%0d] got %b want %b", i, dut.z_s, want[31]);
      end
      checks++;
      if (lat + 1 > 60) begin errors++; $display("FAIL arith_latency[%0d] got %0d want <=60", i, lat + 1); end
      ack_z();
    end
  endtask

  task automatic test_special();
    vec_t v[9];
    logic [31:0] z, want;
    int lat;
    bit hs_ok, z_ok;
    v[0] = '{32'h7F800000, 32'h3F800000, 32'h7F800000};
    v[1] = '{32'hFF800000, 32'h3F800000, 32'hFF800000};
    v[2] = '{32'h7F800000, 32'h7F800000, 32'h7F800000};
    v[3] = '{32'h7F800000, 32'hFF800000, 32'hFFC00000};
    v[4] = '{32'h3F800000, 32'hFF800001, 32'hFFC00000};
    v[5] = '{32'h00000000, 32'h00000000, 32'h00000000};
    v[6] = '{32'h80000000, 32'h80000000, 32'h80000000};
    v[7] = '{32'h00000000, 32'hC0400000, 32'hC0400000};
    v[8] = '{32'h80000000, 32'h00000000, 32'h00000000};
    foreach (v[i]) begin
      exp_q.push_back(v[i].z);
      drive_op(v[i].a, v[i].b, hs_ok);
      wait_z(z, lat, z_ok);
      want = exp_q.pop_front();
      checks++;
      if (!hs_ok || !z_ok || z !== want) begin
        errors++; $display("FAIL special[%0d] got %h want %h (stb seen %b)", i, z, want, z_ok);
      end
      checks++;
      if (lat + 1 > 4) begin errors++; $display("FAIL special_latency[%0d] got %0d want <=4", i, lat + 1); end
      ack_z();
    end
  endtask

  task automatic test_rounding();
    vec_t v[7];
    logic [31:0] z, want;
    int lat;
    bit hs_ok, z_ok;
    v[0] = '{32'h3F800000, 32'h33800000, 32'h3F800000};
    v[1] = '{32'h3F800001, 32'h33800000, 32'h3F800002};
    v[2] = '{32'h3F800000, 32'h33C00000, 32'h3F800001};
    v[3] = '{32'h3F800000, 32'h34000000, 32'h3F800001};
    v[4] = '{32'h3FFFFFFF, 32'h33800000, 32'h40000000};
    v[5] = '{32'h3F800000, 32'hB3800000, 32'h3F7FFFFF};
    v[6] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
    foreach (v[i]) begin
      exp_q.push_back(v[i].z);
      drive_op(v[i].a, v[i].b, hs_ok);
      wait_z(z, lat, z_ok);
      want = exp_q.pop_front();
      checks++;
      if (!hs_ok || !z_ok || z !== want) begin
        errors++; $display("FAIL round[%0d] got %h want %h (stb seen %b)", i, z, want, z_ok);
      end
      ack_z();
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[3];
    logic [31:0] z, want;
    int lat;
    bit hs_ok, z_ok;
    v[0] = '{32'h40400000, 32'h40400000, 32'h40C00000};
    v[1] = '{32'h40A00000, 32'hC0400000, 32'h40000000};
    v[2] = '{32'h41200000, 32'h3F800000, 32'h41300000};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(v[i].z);
      drive_op(v[i].a, v[i].b, hs_ok);
      // Offer the next A early; it must wait until the result is taken.
      if (i < 2) begin
        input_a = v[i+1].a;
        input_a_stb = 1'b1;
      end
      wait_z(z, lat, z_ok);
      want = exp_q.pop_front();
      checks++;
      if (!hs_ok || !z_ok || z !== want) begin
        errors++; $display("FAIL b2b[%0d] got %h want %h (stb seen %b)", i, z, want, z_ok);
      end
      ack_z();
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] z, z_hold, want;
    int lat;
    bit hs_ok, z_ok;
    drive_op(32'h3F800000, 32'h35800000, hs_ok);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({input_a_ack, input_b_ack, output_z_stb} !== 3'b000 || output_z !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs got acks/stb %b z %h want 000 z 00000000",
               {input_a_ack, input_b_ack, output_z_stb}, output_z);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    exp_q.push_back(32'h40000000);
    drive_op(32'h3F800000, 32'h3F800000, hs_ok);
    wait_z(z, lat, z_ok);
    want = exp_q.pop_front();
    checks++;
    if (!hs_ok || !z_ok || z !== want) begin
      errors++; $display("FAIL after_reset got %h want %h (stb seen %b)", z, want, z_ok);
    end
    z_hold = output_z;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (output_z_stb !== 1'b1 || output_z !== want) begin
      errors++; $display("FAIL hold_stb got stb %b z %h want stb 1 z %h", output_z_stb, output_z, want);
    end
    checks++;
    if (output_z !== z_hold) begin errors++; $display("FAIL hold_stable got %h want %h", output_z, z_hold); end
    ack_z();
    checks++;
    if (output_z_stb !== 1'b0) begin errors++; $display("FAIL stb_after_ack got %b want 0", output_z_stb); end
  endtask

  task automatic test_exclusive();
    checks++;
    if (excl_bad !== 0) begin errors++; $display("FAIL exclusive_handshake got %0d overlaps want 0", excl_bad); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_rounding();
    test_back_to_back();
    test_reset_mid_op();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
